// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer.
//   op_t           : 2-bit requester operation (hold / increment / decrement / load)
//   state_t        : sequencer FSM state (idle / op pending)
//   RESET_FILL     : fill bit of the counter reset value (all ones)
//   ID_W           : width of requester indices (up to 8 requesters)
//   rr_next()      : round-robin successor of a winner index, modulo n
package counter_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_LOAD = 2'b11
  } op_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam logic RESET_FILL     = 1'b1;
  localparam int   MAX_REQUESTERS = 8;
  localparam int   ID_W           = 3;

  // Next pointer after a grant: the requester just above the winner gets
  // top priority, wrapping back to 0 after the last requester.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/counter_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter.
//   valid   [N-1:0] : request lines
//   pointer [2:0]   : index holding highest priority this cycle (must be < N)
//   grant   [N-1:0] : one-hot winner, all zero when nothing is valid
//   index   [2:0]   : winner index (0 when nothing is valid)
// The search starts at pointer and walks upward modulo N; the first valid
// line wins. N may be 1..8.
module rr_arbiter
  import counter_sequencer_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]    valid,
  input  logic [ID_W-1:0] pointer,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] index
);

  // Padded to the maximum so that the 3-bit search position can index
  // directly whatever N is.
  logic [MAX_REQUESTERS-1:0] valid_pad;
  logic [MAX_REQUESTERS-1:0] grant_pad;
  logic [3:0]                pos;
  logic                      hit;

  always_comb begin
    valid_pad          = '0;
    valid_pad[N-1:0]   = valid;
    grant_pad          = '0;
    index              = '0;
    hit                = 1'b0;
    pos                = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, pointer} + 4'(k);
      if (pos >= 4'(N)) begin
        pos = pos - 4'(N);
      end
      if (!hit && valid_pad[pos[2:0]]) begin
        hit                 = 1'b1;
        grant_pad[pos[2:0]] = 1'b1;
        index               = pos[2:0];
      end
    end
    grant = grant_pad[N-1:0];
  end

endmodule

// File: rtl/counter_sequencer.sv
// Shared up/down/load counter with round-robin access and a tick-paced update.
//   clock, reset_           : single clock; reset_ is asynchronous, active high
//   req_valid[R]            : per-requester request valid
//   req_op[2R]              : requester i op at [2i+1:2i] (see op_t)
//   req_data[W*R]           : requester i load value at [W*i +: W]
//   req_ready[R]            : one-hot grant (combinational, only in idle)
//   grant_id[3]             : index of the last accepted requester
//   busy                    : an accepted op is waiting for its tick
//   tick                    : one-cycle pulse every DIVIDE cycles
//   value[W]                : counter value
// Handshake: a request is accepted on a rising edge where req_valid[i] and
// req_ready[i] are both high; a requester keeps valid/op/data stable until
// then and may drop valid beforehand to withdraw. Op and data are captured
// at acceptance, so later changes on the request lines have no effect.
// Build option: define COUNTER_SEQUENCER_SATURATE_EN to make increment and
// decrement clamp at all-ones / zero instead of wrapping.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int REQUESTERS = 3,   // 1..8
  parameter int DIVIDE     = 2    // 1..256
) (
  input  logic                        clock,
  input  logic                        reset_,
  input  logic [REQUESTERS-1:0]       req_valid,
  input  logic [2*REQUESTERS-1:0]     req_op,
  input  logic [WIDTH*REQUESTERS-1:0] req_data,
  output logic [REQUESTERS-1:0]       req_ready,
  output logic [ID_W-1:0]             grant_id,
  output logic                        busy,
  output logic                        tick,
  output logic [WIDTH-1:0]            value
);

  localparam int               CW          = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [CW-1:0]    CNT_LAST    = CW'(DIVIDE - 1);
  localparam logic [WIDTH-1:0] RESET_VALUE = {WIDTH{RESET_FILL}};

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic              busy_q, busy_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  op_t               op_q, op_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [WIDTH-1:0]  value_q, value_d;

  logic [REQUESTERS-1:0] arb_grant;
  logic [ID_W-1:0]       arb_index;
  logic                  accept;
  op_t                   op_sel;
  logic [WIDTH-1:0]      data_sel;

  function automatic logic [WIDTH-1:0] apply_op(input op_t op, input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] load);
    logic [WIDTH-1:0] res;
    res = cur;
    case (op)
      OP_HOLD: res = cur;
`ifdef COUNTER_SEQUENCER_SATURATE_EN
      OP_INC:  res = (cur == RESET_VALUE) ? cur : cur + 1'b1;
      OP_DEC:  res = (cur == '0) ? cur : cur - 1'b1;
`else
      OP_INC:  res = cur + 1'b1;
      OP_DEC:  res = cur - 1'b1;
`endif
      OP_LOAD: res = load;
      default: res = cur;
    endcase
    return res;
  endfunction

  rr_arbiter #(.N(REQUESTERS)) u_arb (
    .valid   (req_valid),
    .pointer (ptr_q),
    .grant   (arb_grant),
    .index   (arb_index)
  );

  // Ready is offered only while idle; it is also forced low during reset so
  // nothing looks granted while the block is held.
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && !reset_) begin
      req_ready = arb_grant;
    end
  end

  assign accept = |(req_valid & req_ready);

  // Winner's op/data; arb_grant is one-hot so at most one term matches.
  always_comb begin
    op_sel   = OP_HOLD;
    data_sel = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (arb_grant[i]) begin
        op_sel   = op_t'(req_op[2*i +: 2]);
        data_sel = req_data[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    // Registered, so the pulse lands in the cycle after the last count.
    tick_d  = (cnt_q == CNT_LAST);
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    op_d    = op_q;
    data_d  = data_q;
    value_d = value_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = op_sel;
          data_d  = data_sel;
          gid_d   = arb_index;
          ptr_d   = rr_next(arb_index, REQUESTERS);
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        // tick_q seen here is always from a cycle after acceptance, so a
        // tick coinciding with the accept edge is never consumed.
        if (tick_q) begin
          value_d = apply_op(op_q, value_q, data_q);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_PENDING);
  end

  always_ff @(posedge clock or posedge reset_) begin
    if (reset_) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      gid_q   <= '0;
      op_q    <= OP_HOLD;
      data_q  <= '0;
      value_q <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      op_q    <= op_d;
      data_q  <= data_d;
      value_q <= value_d;
    end
  end

  assign grant_id = gid_q;
  assign busy     = busy_q;
  assign tick     = tick_q;
  assign value    = value_q;

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Shares one WIDTH-bit up/down/load counter between REQUESTERS independent requesters using a valid/ready handshake and round-robin arbitration.
- Applies accepted operations only on a divided-clock enable tick. This replaces the toggled half-clock with a single-clock enable.
- Sits between input sources (mouse button, mouse position, reset logic) and the counter value consumer.

Parameters:
- WIDTH, 8, counter and load-data width.
- REQUESTERS, 3, number of requester ports, legal range 1..8.
- DIVIDE, 2, tick period in clock cycles, legal range 1..256. DIVIDE=1 means a tick every cycle.

Ports:
- clock  input  1  sole clock, rising edge.
- reset_  input  1  asynchronous, active-high reset.
- req_valid  input  REQUESTERS  per-requester request valid.
- req_op  input  2*REQUESTERS  per-requester op, requester i at [2i+1:2i]: 00 hold, 01 increment, 10 decrement, 11 load.
- req_data  input  WIDTH*REQUESTERS  per-requester load value, requester i at [WIDTH*i +: WIDTH].
- req_ready  output  REQUESTERS  one-hot grant; the request is accepted in a cycle where valid and ready are both high.
- grant_id  output  3  index of the last accepted requester.
- busy  output  1  high while an accepted op is pending.
- tick  output  1  high for one cycle every DIVIDE cycles.
- value  output  WIDTH  current counter value.

Behaviour:
- Reset (asynchronous, while reset_ high):
  - value = all ones.
  - Prescaler = 0, tick = 0, busy = 0.
  - req_ready = 0, grant_id = 0.
  - Round-robin pointer = 0.
  - Any pending op is discarded. Reset mid-operation never applies the pending op.
- Prescaler:
  - Counts 0..DIVIDE-1, then wraps.
  - tick is registered and is high in the cycle after the prescaler equals DIVIDE-1. The first tick occurs DIVIDE cycles after reset release.
- FSM state IDLE:
  - req_ready is combinational: one-hot on the first valid requester, searching from the pointer upward modulo REQUESTERS.
  - If no requester is valid, req_ready = 0.
  - On acceptance: latch op and data, set grant_id, move pointer to winner+1 mod REQUESTERS, go to PENDING.
- FSM state PENDING:
  - busy = 1, req_ready = 0.
  - On the first clock edge where tick is high: apply the op and return to IDLE.
  - Acceptance at edge t is applied no earlier than edge t+1 and no later than edge t+DIVIDE.
  - If tick is high in the acceptance cycle itself, it is ignored for that op.
- Throughput: at most one op per tick period. IDLE→PENDING→IDLE takes at least 2 cycles.
- Arithmetic:
  - Increment and decrement are modulo 2^WIDTH: all-ones + 1 = 0, 0 - 1 = all-ones.
  - Load takes req_data of the winner, captured at acceptance. Later changes to req_data are ignored.
  - Hold is accepted and consumes a tick slot; value is unchanged.
- Simultaneous requests: exactly one grant per acceptance, with rotating priority. A requester holding valid is served within REQUESTERS acceptances.
- Requesters must hold req_valid, req_op and req_data stable until accepted. Dropping valid before acceptance withdraws the request without error.

Optional Feature:
- Macro: COUNTER_SEQUENCER_SATURATE_EN.
- Defined: increment at all-ones holds all-ones, and decrement at 0 holds 0. Load and hold are unchanged.
- Undefined: modulo wrap as described in Behaviour.

Decomposition:
- Shared package counter_sequencer_pkg contains:
  - Op typedef, 2 bits: OP_HOLD, OP_INC, OP_DEC, OP_LOAD.
  - FSM state typedef: ST_IDLE, ST_PENDING.
  - Reset-value constant (all ones).
- One sub-module, rr_arbiter: parameter N; inputs valid, pointer; outputs one-hot grant and index. Purely combinational, reused for any future shared resources.

Test Plan:
- Reset, WIDTH=8, DIVIDE=2 → value=0xFF, busy=0, req_ready=0; first tick 2 cycles after release.
- Requester 0 sends INC at value 0xFF → accepted; value becomes 0x00 at the next tick edge. With the saturate macro defined, value stays 0xFF.
- Requesters 0, 1, 2 all valid with LOAD 0x10, 0x20, 0x30, pointer 0 → grant order 0, 1, 2; value sequence 0x10, 0x20, 0x30, one op per tick; grant_id 0, 1, 2.
- Requester 1 sends DEC from value 0x00, DIVIDE=4 → value becomes 0xFF within 4 cycles of acceptance; busy high until then.
- Requester 2 LOAD 0x55 accepted, reset_ pulsed before the tick → value=0xFF, busy=0; 0x55 is never applied.
- DIVIDE=1, requester 0 holding a continuous INC from 0x00 → value increments every 2 cycles: 0x01, 0x02, 0x03…
